// File: rtl/crc_frame_packer_if.sv
// Stream and CRC-engine signal bundle for crc_frame_packer.
// The slave modport is the packer itself; the master modport is whatever
// surrounds it (upstream source, CRC engine, downstream sink).
interface crc_frame_packer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        crc_clr;
  logic [31:0] crc_data;
  logic        crc_rd;
  logic [31:0] crc_in;
  logic        crc_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        frame_err;

  modport master (
    output in_data, in_valid, in_last, crc_in, crc_ready, out_ready,
    input  in_ready, crc_clr, crc_data, crc_rd, out_data, out_valid, out_last, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, crc_in, crc_ready, out_ready,
    output in_ready, crc_clr, crc_data, crc_rd, out_data, out_valid, out_last, frame_err
  );
endinterface

// File: rtl/crc_frame_packer.sv
// Frame assembler in front of a CRC32 engine: buffers a payload frame while
// streaming it into the engine, then emits header, payload and CRC trailer.
module crc_frame_packer #(
  parameter int          DEPTH   = 16,
  parameter int          AW      = 4,
  parameter logic [15:0] HDR_TAG = 16'hC3A5
) (
  input logic               clk,
  input logic               rst,
  crc_frame_packer_if.slave bus
);

  typedef enum logic [2:0] {
    CLR,
    COLLECT,
    WAIT_CRC,
    HDR,
    PAY,
    TAIL
  } state_t;

  // Count value reached just before the DEPTH-th beat is accepted.
  localparam logic [AW:0] LAST_CNT = (AW + 1)'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [AW:0] wrCnt_q, wrCnt_d;
  logic [AW:0] rdCnt_q, rdCnt_d;
  logic        crcClr_q, crcClr_d;
  logic        waitArmed_q;
  logic [31:0] crcVal_q;
  logic [31:0] crcData_q;
  logic        crcRd_q;
  logic [31:0] mem_q [DEPTH];

  logic        inAccept;
  logic        crcLatch;
  logic        frameErr;
  logic        inReady;
  logic        outValid;
  logic        outLast;
  logic [31:0] outData;
  logic [15:0] hdrCount;

  assign hdrCount = 16'(wrCnt_q);

  // Next-state and output decode; CLR spends one cycle idle and one cycle pulsing crc_clr so the pulse never overlaps reset.
  always_comb begin
    state_d  = state_q;
    wrCnt_d  = wrCnt_q;
    rdCnt_d  = rdCnt_q;
    crcClr_d = 1'b0;
    inAccept = 1'b0;
    crcLatch = 1'b0;
    frameErr = 1'b0;
    inReady  = 1'b0;
    outValid = 1'b0;
    outLast  = 1'b0;
    outData  = 32'h0;
    case (state_q)
      CLR: begin
        wrCnt_d = '0;
        rdCnt_d = '0;
        if (!crcClr_q) begin
          crcClr_d = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          inAccept = 1'b1;
          wrCnt_d  = wrCnt_q + 1'b1;
          if (bus.in_last) begin
            state_d = WAIT_CRC;
          end else if (wrCnt_q == LAST_CNT) begin
            state_d  = WAIT_CRC;
            frameErr = 1'b1;
          end
        end
      end
      WAIT_CRC: begin
        if (waitArmed_q && bus.crc_ready) begin
          crcLatch = 1'b1;
          state_d  = HDR;
        end
      end
      HDR: begin
        outValid = 1'b1;
        outData  = {HDR_TAG, hdrCount};
        if (bus.out_ready) begin
          state_d = PAY;
        end
      end
      PAY: begin
        outValid = 1'b1;
        outData  = mem_q[rdCnt_q[AW-1:0]];
        if (bus.out_ready) begin
          rdCnt_d = rdCnt_q + 1'b1;
          if (rdCnt_d == wrCnt_q) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        outValid = 1'b1;
        outLast  = 1'b1;
        outData  = crcVal_q;
        if (bus.out_ready) begin
          state_d = CLR;
        end
      end
      default: begin
        state_d = CLR;
      end
    endcase
  end

  // State, counters and CRC-side registers; waitArmed_q masks crc_ready in the first WAIT_CRC cycle (the final crc_rd cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLR;
      wrCnt_q     <= '0;
      rdCnt_q     <= '0;
      crcClr_q    <= 1'b0;
      waitArmed_q <= 1'b0;
      crcVal_q    <= 32'h0;
      crcData_q   <= 32'h0;
      crcRd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrCnt_q     <= wrCnt_d;
      rdCnt_q     <= rdCnt_d;
      crcClr_q    <= crcClr_d;
      waitArmed_q <= (state_q == WAIT_CRC);
      crcRd_q     <= inAccept;
      if (inAccept) begin
        crcData_q <= bus.in_data;
      end
      if (crcLatch) begin
        crcVal_q <= bus.crc_in;
      end
    end
  end

  // Payload buffer; contents are only meaningful below the current count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (inAccept) begin
      mem_q[wrCnt_q[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.crc_clr   = crcClr_q;
  assign bus.crc_data  = crcData_q;
  assign bus.crc_rd    = crcRd_q;
  assign bus.out_data  = outData;
  assign bus.out_valid = outValid;
  assign bus.out_last  = outLast;
  assign bus.frame_err = frameErr;

endmodule

// File: tb/tb_crc_frame_packer.sv
// Self-checking bench for crc_frame_packer: table of short frames plus
// directed sequences for truncation, backpressure, stale crc_ready and reset.
module tb_crc_frame_packer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  crc_frame_packer_if bus();

  crc_frame_packer #(
    .DEPTH  (16),
    .AW     (4),
    .HDR_TAG(16'hC3A5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          n;
    logic [31:0] w [4];
    logic [31:0] crcVal;
    logic [31:0] expHdr;
  } vec_t;

  vec_t vecs [4];

  int vecCount = 0;
  int errCount = 0;
  int cyc = 0;

  logic [31:0] outWords [$];
  logic        outLasts [$];
  int          outCycles [$];
  logic [31:0] rdWords [$];
  int          rdCycles [$];
  int          clrCycles [$];
  int          rdTotal = 0;
  int          errPulses = 0;
  int          lastErrCycle = -1;
  int          lastCount = 0;

  int lastBase;
  int errBase;
  int rdBase;

  // Free-running cycle index used to timestamp observed events.
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampling on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.crc_rd) begin
      rdWords.push_back(bus.crc_data);
      rdCycles.push_back(cyc);
      rdTotal++;
    end
    if (bus.frame_err) begin
      errPulses++;
      lastErrCycle = cyc;
    end
    if (bus.crc_clr) clrCycles.push_back(cyc);
    if (bus.out_valid && bus.out_ready) begin
      outWords.push_back(bus.out_data);
      outLasts.push_back(bus.out_last);
      outCycles.push_back(cyc);
      if (bus.out_last) lastCount++;
    end
  end

  // Hard stop in case something upstream of the bounded waits goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearMonitor();
    outWords.delete();
    outLasts.delete();
    outCycles.delete();
    rdWords.delete();
    rdCycles.delete();
    lastBase = lastCount;
    errBase  = errPulses;
    rdBase   = rdTotal;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) compare("send_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic serveCrc(input int target, input logic [31:0] val);
    int n = 0;
    while (rdTotal < target && n < 200) begin
      tick();
      n++;
    end
    compare("crc_rd_total", 32'(rdTotal), 32'(target));
    bus.crc_in    = val;
    bus.crc_ready = 1'b1;
    tick();
    bus.crc_ready = 1'b0;
  endtask

  task automatic waitLast(input int target);
    int n = 0;
    while (lastCount < target && n < 300) begin
      tick();
      n++;
    end
    compare("out_last_count", 32'(lastCount), 32'(target));
  endtask

  task automatic setVec(input int idx, input int n, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] crcVal,
                        input logic [31:0] expHdr);
    vecs[idx].n      = n;
    vecs[idx].w[0]   = w0;
    vecs[idx].w[1]   = w1;
    vecs[idx].w[2]   = w2;
    vecs[idx].w[3]   = w3;
    vecs[idx].crcVal = crcVal;
    vecs[idx].expHdr = expHdr;
  endtask

  task automatic checkResetOutputs(input string tag);
    compare({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    compare({tag, "_crc_clr"},   32'(bus.crc_clr),   32'd0);
    compare({tag, "_crc_rd"},    32'(bus.crc_rd),    32'd0);
    compare({tag, "_crc_data"},  bus.crc_data,       32'd0);
    compare({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    compare({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    compare({tag, "_out_data"},  bus.out_data,       32'd0);
    compare({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    clearMonitor();
    bus.out_ready = 1'b1;
    for (int i = 0; i < v.n; i++) sendWord(v.w[i], (i == v.n - 1));
    serveCrc(rdBase + v.n, v.crcVal);
    compare("hdr_latency_valid", 32'(bus.out_valid), 32'd1);
    waitLast(lastBase + 1);
  endtask

  task automatic checkOutput(input vec_t v);
    int lasts = 0;
    compare("out_len", 32'(outWords.size()), 32'(v.n + 2));
    if (outWords.size() == v.n + 2) begin
      compare("hdr", outWords[0], v.expHdr);
      for (int i = 0; i < v.n; i++) compare("payload", outWords[i + 1], v.w[i]);
      compare("trailer", outWords[v.n + 1], v.crcVal);
      compare("trailer_last", 32'(outLasts[v.n + 1]), 32'd1);
      foreach (outLasts[i]) if (outLasts[i]) lasts++;
      compare("last_count", 32'(lasts), 32'd1);
      compare("out_span", 32'(outCycles[v.n + 1] - outCycles[0]), 32'(v.n + 1));
    end
    compare("rd_count", 32'(rdWords.size()), 32'(v.n));
    if (rdWords.size() == v.n) begin
      for (int i = 0; i < v.n; i++) compare("rd_data", rdWords[i], v.w[i]);
      compare("rd_span", 32'(rdCycles[v.n - 1] - rdCycles[0]), 32'(v.n - 1));
    end
    compare("frame_err_none", 32'(errPulses - errBase), 32'd0);
  endtask

  initial begin
    logic [31:0] expQ [$];
    logic [31:0] bpExp [5];
    int          idx;
    int          n;
    int          clrBetween;

    setVec(0, 1, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'hC3A50001);
    setVec(1, 4, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'hDEADBEEF, 32'hC3A50004);
    setVec(2, 3, 32'hFFFFFFFF, 32'h00000000, 32'h80000001, 32'h0, 32'h0BADF00D, 32'hC3A50003);
    setVec(3, 2, 32'h13579BDF, 32'h2468ACE0, 32'h0, 32'h0, 32'h00000000, 32'hC3A50002);

    rst           = 1'b1;
    bus.in_data   = 32'h0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.crc_in    = 32'h0;
    bus.crc_ready = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values, then crc_clr on the first edge and in_ready one cycle later.
    repeat (2) tick();
    checkResetOutputs("rst");
    rst = 1'b0;
    tick();
    compare("first_clr", 32'(bus.crc_clr), 32'd1);
    compare("first_clr_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    compare("clr_done", 32'(bus.crc_clr), 32'd0);
    compare("in_ready_up", 32'(bus.in_ready), 32'd1);

    // Table of ordinary frames with out_ready held high.
    for (int k = 0; k < 4; k++) begin
      $display("[TB] frame vector %0d, %0d words", k, vecs[k].n);
      applyStimulus(vecs[k]);
      checkOutput(vecs[k]);
    end

    // Truncation: 18 words, last on word 18, splits into 16 + 2.
    $display("[TB] truncation sequence");
    clearMonitor();
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 18; i++) sendWord(32'h100 + 32'(i), (i == 18));
      end
      begin
        serveCrc(rdBase + 16, 32'hC0C00001);
        serveCrc(rdBase + 18, 32'hC0C00002);
      end
    join
    waitLast(lastBase + 2);
    expQ.push_back(32'hC3A50010);
    for (int i = 1; i <= 16; i++) expQ.push_back(32'h100 + 32'(i));
    expQ.push_back(32'hC0C00001);
    expQ.push_back(32'hC3A50002);
    expQ.push_back(32'h00000111);
    expQ.push_back(32'h00000112);
    expQ.push_back(32'hC0C00002);
    compare("trunc_len", 32'(outWords.size()), 32'd22);
    if (outWords.size() == 22) begin
      foreach (expQ[i]) compare("trunc_word", outWords[i], expQ[i]);
      compare("trunc_last1", 32'(outLasts[17]), 32'd1);
      compare("trunc_last2", 32'(outLasts[21]), 32'd1);
    end
    compare("trunc_err_pulses", 32'(errPulses - errBase), 32'd1);
    compare("trunc_rd_count", 32'(rdWords.size()), 32'd18);
    if (rdWords.size() == 18) begin
      compare("trunc_err_cycle", 32'(lastErrCycle), 32'(rdCycles[15] - 1));
      compare("trunc_rd17", rdWords[16], 32'h00000111);
      clrBetween = 0;
      foreach (clrCycles[i]) if (clrCycles[i] > rdCycles[15] && clrCycles[i] < rdCycles[16]) clrBetween++;
      compare("trunc_clr_between", 32'(clrBetween), 32'd1);
    end

    // Backpressure: toggle out_ready every cycle while a word waits upstream.
    $display("[TB] backpressure sequence");
    clearMonitor();
    bus.out_ready = 1'b1;
    sendWord(32'hB0000001, 1'b0);
    sendWord(32'hB0000002, 1'b0);
    sendWord(32'hB0000003, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hE0E0E0E0;
    bus.in_last  = 1'b1;
    serveCrc(rdBase + 3, 32'hBEEF0003);
    bpExp[0] = 32'hC3A50003;
    bpExp[1] = 32'hB0000001;
    bpExp[2] = 32'hB0000002;
    bpExp[3] = 32'hB0000003;
    bpExp[4] = 32'hBEEF0003;
    idx = 0;
    n   = 0;
    while (idx < 5 && n < 60) begin
      compare("bp_valid", 32'(bus.out_valid), 32'd1);
      compare("bp_data", bus.out_data, bpExp[idx]);
      compare("bp_in_ready", 32'(bus.in_ready), 32'd0);
      bus.out_ready = ~bus.out_ready;
      if (bus.out_valid && bus.out_ready) idx++;
      tick();
      n++;
    end
    compare("bp_words", 32'(idx), 32'd5);
    bus.out_ready = 1'b1;
    sendWord(32'hE0E0E0E0, 1'b1);
    serveCrc(rdBase + 4, 32'hBEEF0004);
    waitLast(lastBase + 2);
    compare("bp_out_len", 32'(outWords.size()), 32'd8);
    if (outWords.size() == 8) begin
      compare("bp_trailer_last", 32'(outLasts[4]), 32'd1);
      compare("bp_f2_hdr", outWords[5], 32'hC3A50001);
      compare("bp_f2_word", outWords[6], 32'hE0E0E0E0);
      compare("bp_f2_crc", outWords[7], 32'hBEEF0004);
    end
    compare("bp_rd_count", 32'(rdWords.size()), 32'd4);

    // Stale crc_ready: held high throughout; must latch only in the second WAIT_CRC cycle.
    $display("[TB] stale crc_ready sequence");
    clearMonitor();
    bus.out_ready = 1'b1;
    bus.crc_ready = 1'b1;
    bus.crc_in    = 32'h0BAD0BAD;
    sendWord(32'h00000051, 1'b0);
    compare("stale_no_out_mid", 32'(bus.out_valid), 32'd0);
    sendWord(32'h00000052, 1'b1);
    compare("stale_wait1_idle", 32'(bus.out_valid), 32'd0);
    bus.crc_in = 32'hAAAA0001;
    tick();
    compare("stale_wait2_idle", 32'(bus.out_valid), 32'd0);
    bus.crc_in = 32'h55550002;
    tick();
    compare("stale_hdr_valid", 32'(bus.out_valid), 32'd1);
    compare("stale_hdr", bus.out_data, 32'hC3A50002);
    bus.crc_ready = 1'b0;
    bus.crc_in    = 32'h0;
    waitLast(lastBase + 1);
    compare("stale_len", 32'(outWords.size()), 32'd4);
    if (outWords.size() == 4) compare("stale_crc", outWords[3], 32'h55550002);

    // Reset in the middle of the payload phase.
    $display("[TB] reset mid-payload sequence");
    clearMonitor();
    bus.out_ready = 1'b1;
    sendWord(32'h000000F1, 1'b0);
    sendWord(32'h000000F2, 1'b0);
    sendWord(32'h000000F3, 1'b0);
    sendWord(32'h000000F4, 1'b1);
    serveCrc(rdBase + 4, 32'hFACEFACE);
    repeat (3) tick();
    compare("mid_pay_valid", 32'(bus.out_valid), 32'd1);
    compare("mid_pay_data", bus.out_data, 32'h000000F3);
    rst = 1'b1;
    #1;
    checkResetOutputs("midrst");
    repeat (3) tick();
    compare("midrst_out_count", 32'(outWords.size()), 32'd3);
    rst = 1'b0;
    tick();
    compare("midrst_clr", 32'(bus.crc_clr), 32'd1);
    compare("midrst_clr_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    compare("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    compare("midrst_no_out", 32'(bus.out_valid), 32'd0);
    compare("midrst_out_count_after", 32'(outWords.size()), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/crc_frame_packer.md
# crc_frame_packer

Frame assembler that sits upstream of the CRC32 engine and owns its input side. Payload words are accepted over a valid/ready stream, buffered, and forwarded one per cycle to the engine's `data`/`rd` inputs. When the engine signals `out_ready_CRC`, the block emits the frame on its output stream: a header word, the buffered payload, then the captured CRC word.

## Interface
- `DEPTH`, default 16: payload buffer depth in words; this is the maximum frame length. Must be a power of two, ≤ 256.
- `AW`, default 4: buffer address width, log2(DEPTH).
- `HDR_TAG`, default 16'hC3A5: constant placed in the upper half of the header word.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 32: payload word.
- `in_valid` input 1: `in_data` is valid.
- `in_last` input 1: last word of the frame; qualified by `in_valid`.
- `in_ready` output 1: block accepts a word this cycle.
- `crc_clr` output 1: one-cycle pulse; tied to the CRC engine's clear/start.
- `crc_data` output 32: word to the CRC engine (`data`).
- `crc_rd` output 1: one-cycle strobe per word to the CRC engine (`rd`).
- `crc_in` input 32: CRC result from the engine (`CRC`).
- `crc_ready` input 1: engine result valid (`out_ready_CRC`).
- `out_data` output 32: frame word.
- `out_valid` output 1: `out_data` is valid.
- `out_last` output 1: marks the CRC trailer word.
- `out_ready` input 1: downstream accepts a word.
- `frame_err` output 1: one-cycle pulse when a frame is truncated at `DEPTH`.

## Operation
- States: CLR, COLLECT, WAIT_CRC, HDR, PAY, TAIL. Reset enters CLR.
- **CLR**: `crc_clr`=1 for exactly one cycle, write/read pointers and word count zeroed, then go to COLLECT.
- **COLLECT**:
  - `in_ready`=1, combinational from state.
  - Each beat with `in_valid` & `in_ready` writes `in_data` to the buffer at the write pointer and increments the count (range 1..DEPTH).
  - The beat is registered onto `crc_data`, with `crc_rd`=1 for exactly the following cycle.
  - On an accepted beat with `in_last`=1, go to WAIT_CRC.
  - On acceptance of the DEPTH-th beat with `in_last`=0, go to WAIT_CRC and pulse `frame_err` that cycle. Later upstream words start the next frame.
- **WAIT_CRC**:
  - `in_ready`=0.
  - `crc_ready` is ignored in the first cycle, which is the final `crc_rd` cycle.
  - From the second cycle on, the first cycle with `crc_ready`=1 latches `crc_in` into the CRC register and goes to HDR.
  - No timeout; the block waits indefinitely.
- **HDR**: `out_data` = {HDR_TAG, 16'(count)}, `out_valid`=1. On `out_valid` & `out_ready`, go to PAY.
- **PAY**: `out_data` = buffer word at the read pointer. Each handshake advances the read pointer. After the handshake on word number count, go to TAIL.
- **TAIL**: `out_data` = latched CRC, `out_last`=1. On handshake, go to CLR.
- Output stream rules:
  - `out_valid` and `out_data` are held stable while `out_ready`=0.
  - No bubbles between words when `out_ready` stays high.
- A frame on the output is always count+2 words.

## Timing
- Reset values (asserted asynchronously and held during `rst`): `in_ready`=0, `crc_clr`=0, `crc_rd`=0, `crc_data`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `frame_err`=0.
- First `crc_clr` pulse: the first clock edge after `rst` deasserts.
- `in_ready` rises one cycle after `crc_clr`.
- Word accepted at edge N: `crc_rd`=1 in cycle N+1 with the matching `crc_data`.
- Back-to-back accepted beats give back-to-back `crc_rd` cycles.
- Minimum time from `crc_ready` sampled high to header valid: 1 cycle.
- Reset mid-frame or mid-output: the partial frame is discarded, nothing further is emitted, and the block restarts at CLR.
- `in_valid` during WAIT/HDR/PAY/TAIL is back-pressured (`in_ready`=0); no data is lost.
- `crc_ready` high during CLR or COLLECT is ignored.

## Test plan
- Single-word frame: `in_data`=32'hAAAA5555, `in_last`=1, CRC stub returns 32'h12345678 two cycles later. Output must be C3A5_0001, AAAA5555, 12345678 with `out_last` on word 3. Exactly one `crc_rd` pulse, carrying AAAA5555.
- 4-word frame 1,2,3,4 with `out_ready` held high. Output must be C3A5_0004, 1, 2, 3, 4, CRC word, on 6 consecutive cycles; `crc_rd` pulses on 4 consecutive cycles.
- Truncation: 18 words sent with `in_last` on word 18. Frame 1 must contain count 16 plus words 1–16, with one `frame_err` pulse. Frame 2 must contain count 2 plus words 17–18. `crc_clr` must pulse before each frame.
- Backpressure: toggle `out_ready` every cycle during a 3-word frame. Data must be held stable while stalled, nothing dropped or duplicated, and `in_ready`=0 throughout output.
- Stale `crc_ready`: hold `crc_ready`=1 constantly. The CRC must latch only in the second WAIT_CRC cycle, and no frame may be emitted before `in_last`.
- Reset mid-PAY: assert `rst` after 2 payload words. All outputs must go to 0 immediately, then `crc_clr` must pulse and `in_ready`=1 after release.
